// File: rtl/learn_mode_sequencer_if.sv
// Signal bundle between the learning-mode sequencer and its neighbours:
// keyboard debouncer, song ROM, buzzer driver and LED/score display.
interface learn_mode_sequencer_if;
    logic       start;
    logic       abort;
    logic [4:0] song_len;
    logic [6:0] user_keys;
    logic [4:0] rom_addr;
    logic [3:0] rom_data;
    logic       key_on;
    logic [3:0] key;
    logic [3:0] expected_key;
    logic       expected_valid;
    logic       err_flash;
    logic       busy;
    logic       done;
    logic [7:0] hits;
    logic [7:0] misses;

    modport master (
        output start, abort, song_len, user_keys, rom_data,
        input  rom_addr, key_on, key, expected_key, expected_valid,
               err_flash, busy, done, hits, misses
    );

    modport slave (
        input  start, abort, song_len, user_keys, rom_data,
        output rom_addr, key_on, key, expected_key, expected_valid,
               err_flash, busy, done, hits, misses
    );
endinterface

// File: rtl/learn_mode_sequencer.sv
// Learning-mode sequencer: steps through a song held in ROM, grades each key press,
// drives the buzzer, and passes the keyboard straight to the buzzer while idle.
module learn_mode_sequencer #(
    parameter int unsigned NOTE_TICKS    = 50_000_000,
    parameter int unsigned GAP_TICKS     = 25_000_000,
    parameter int unsigned ERR_TICKS     = 25_000_000,
    parameter int unsigned TIMEOUT_TICKS = 500_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    learn_mode_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_PLAY, S_GAP, S_ERROR, S_DONE
    } state_t;

    localparam logic [31:0] NOTE_LAST    = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_TICKS - 1);
    localparam logic [31:0] ERR_LAST     = 32'(ERR_TICKS - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_TICKS - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [4:0]  idx;
    logic [4:0]  last_idx;
    logic [6:0]  prev_keys;
    logic [4:0]  rom_addr;
    logic        key_on;
    logic [3:0]  key;
    logic [3:0]  expected_key;
    logic        expected_valid;
    logic        err_flash;
    logic        busy;
    logic        done;
    logic [7:0]  hits;
    logic [7:0]  misses;

    logic        press;
    logic        single;
    logic        match;
    logic [3:0]  key_code;

    always_comb begin
        key_code = '0;
        for (int i = 0; i < 7; i++)
            if (bus.user_keys[i]) key_code = 4'(i);
    end

    // A press is the first cycle of any non-zero keyboard pattern, so a key held
    // across state changes never counts twice.
    assign single = $onehot(bus.user_keys);
    assign press  = (bus.user_keys != '0) && (prev_keys == '0);
    assign match  = single && (key_code == expected_key);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State change plus the status flags that are pure functions of the new state.
    task automatic goto(input state_t s);
        state          <= s;
        cnt            <= '0;
        busy           <= !(s == S_IDLE || s == S_DONE);
        done           <= (s == S_DONE);
        expected_valid <= (s == S_WAIT);
        err_flash      <= (s == S_ERROR);
    endtask

    task automatic start_lesson();
        idx      <= '0;
        rom_addr <= '0;
        hits     <= '0;
        misses   <= '0;
        last_idx <= (bus.song_len == 5'd0) ? 5'd0 : bus.song_len - 5'd1;
        goto(S_FETCH);
    endtask

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            last_idx       <= '0;
            prev_keys      <= '0;
            rom_addr       <= '0;
            key_on         <= 1'b0;
            key            <= '0;
            expected_key   <= '0;
            expected_valid <= 1'b0;
            err_flash      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            hits           <= '0;
            misses         <= '0;
        end else begin
            prev_keys <= bus.user_keys;
            key_on    <= 1'b0;
            if (bus.abort) begin
                goto(S_IDLE);
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            start_lesson();
                        end else if (single) begin
                            key_on <= 1'b1;
                            key    <= key_code;
                        end
                    end
                    S_DONE: begin
                        if (bus.start) start_lesson();
                    end
                    S_FETCH: begin
                        // rom_addr is already set on entry so a registered ROM has its
                        // data ready by LOAD; rewriting it here keeps the two in step.
                        rom_addr <= idx;
                        goto(S_LOAD);
                    end
                    S_LOAD: begin
                        expected_key <= bus.rom_data;
                        goto(S_WAIT);
                    end
                    S_WAIT: begin
                        cnt <= cnt + 32'd1;
                        if (press) begin
                            if (match) begin
                                hits   <= sat_inc(hits);
                                key_on <= 1'b1;
                                key    <= expected_key;
                                goto(S_PLAY);
                            end else begin
                                misses <= sat_inc(misses);
                                goto(S_ERROR);
                            end
                        end else if (cnt == TIMEOUT_LAST) begin
                            misses <= sat_inc(misses);
                            goto(S_ERROR);
                        end
                    end
                    S_PLAY: begin
                        cnt <= cnt + 32'd1;
                        if (cnt == NOTE_LAST) goto(S_GAP);
                        else key_on <= 1'b1;
                    end
                    S_GAP: begin
                        cnt <= cnt + 32'd1;
                        if (cnt == GAP_LAST) begin
                            if (idx == last_idx) begin
                                goto(S_DONE);
                            end else begin
                                idx      <= idx + 5'd1;
                                rom_addr <= idx + 5'd1;
                                goto(S_FETCH);
                            end
                        end
                    end
                    S_ERROR: begin
                        cnt <= cnt + 32'd1;
                        if (cnt == ERR_LAST) goto(S_WAIT);
                    end
                    default: goto(S_IDLE);
                endcase
            end
        end
    end

    assign bus.rom_addr       = rom_addr;
    assign bus.key_on         = key_on;
    assign bus.key            = key;
    assign bus.expected_key   = expected_key;
    assign bus.expected_valid = expected_valid;
    assign bus.err_flash      = err_flash;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.hits           = hits;
    assign bus.misses         = misses;
endmodule

// File: tb/tb_learn_mode_sequencer.sv
// Randomized scoreboard bench for learn_mode_sequencer: the driver predicts each
// lesson event from the song and its own key choices; a monitor pops and compares.
module tb_learn_mode_sequencer;
    localparam int NOTE_T = 4;
    localparam int GAP_T  = 2;
    localparam int ERR_T  = 3;
    localparam int TO_T   = 10;

    localparam int K_WAIT = 0;
    localparam int K_PLAY = 1;
    localparam int K_ERR  = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int kind;
        int key;
        int len;
        int hits;
        int misses;
    } ev_t;

    logic clk;
    logic rst;
    learn_mode_sequencer_if bus();

    learn_mode_sequencer #(
        .NOTE_TICKS(NOTE_T), .GAP_TICKS(GAP_T),
        .ERR_TICKS(ERR_T), .TIMEOUT_TICKS(TO_T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rom_mem [32];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;
    int  h = 0;
    int  m = 0;

    function automatic string kname(input int k);
        case (k)
            K_WAIT:  return "wait";
            K_PLAY:  return "play";
            K_ERR:   return "error";
            default: return "done";
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int key, input int len);
        ev_t e;
        e.kind = kind; e.key = key; e.len = len; e.hits = h; e.misses = m;
        sb.push_back(e);
    endtask

    task automatic compare(input int kind, input int key, input int len);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got %s key=%0d len=%0d, want no event",
                     kname(kind), key, len);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.key != key || e.len != len ||
            e.hits != int'(bus.hits) || e.misses != int'(bus.misses)) begin
            errors++;
            $display("FAIL sb_%s: got %s key=%0d len=%0d hits=%0d misses=%0d, want %s key=%0d len=%0d hits=%0d misses=%0d",
                     kname(e.kind), kname(kind), key, len, bus.hits, bus.misses,
                     kname(e.kind), e.key, e.len, e.hits, e.misses);
        end
    endtask

    // Monitor: each lesson event is compared when its output pulse ends.
    int   wait_len = 0, play_len = 0, err_len = 0, quiet = 0;
    bit   play_run = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done && !prev_done) compare(K_DONE, int'(bus.expected_key), quiet);
            prev_done = bus.done;
            if (bus.expected_valid) wait_len++;
            else if (wait_len != 0) begin
                compare(K_WAIT, int'(bus.expected_key), wait_len);
                wait_len = 0;
            end
            if (bus.key_on && (play_run || bus.busy)) begin
                play_run = 1'b1;
                play_len++;
            end else if (play_run && !bus.key_on) begin
                compare(K_PLAY, int'(bus.key), play_len);
                play_run = 1'b0;
                play_len = 0;
            end
            if (bus.err_flash) err_len++;
            else if (err_len != 0) begin
                compare(K_ERR, int'(bus.expected_key), err_len);
                err_len = 0;
            end
            if (bus.key_on || bus.expected_valid) quiet = 0;
            else quiet++;
        end
    end

    task automatic wait_ev();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.expected_valid && n < 200);
        if (!bus.expected_valid) begin
            checks++; errors++;
            $display("FAIL wait_expected_valid: got no WAIT_KEY in 200 cycles, want one");
        end
    endtask

    task automatic wait_fall();
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.expected_valid && n < 200);
        if (bus.expected_valid) begin
            checks++; errors++;
            $display("FAIL wait_timeout: got expected_valid stuck high, want it to drop");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.done && n < 200);
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL wait_done: got done=0 after 200 cycles, want 1");
        end
    endtask

    // Release the keyboard for one cycle, then present k; the press lands d+1
    // cycles into WAIT_KEY.
    task automatic press_at(input int d, input logic [6:0] k, input bit poke);
        repeat (d) @(negedge clk);
        bus.user_keys = '0;
        @(negedge clk);
        bus.user_keys = k;
        if (poke) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // 0 correct, 1 wrong single key, 2 multi-key, 3 no press (timeout)
    function automatic int pick(input int mode, input int i, input int tries);
        if (mode == 1 && i == 0) return (tries < 257) ? 1 : 0;
        if (mode == 2) return 0;
        if (mode == 3 && i == 0) return (tries == 0) ? 1 : 0;
        if (mode == 4 && i == 0) return (tries == 0) ? 3 : 0;
        if (mode == 4 && i == 1) return (tries == 0) ? 2 : 0;
        if (tries >= 3) return 0;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic run_lesson(input int len, input int mode);
        int leff;
        leff = (len == 0) ? 1 : len;
        bus.song_len = 5'(len);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        h = 0;
        m = 0;
        for (int i = 0; i < leff; i++) begin
            int note, tries, act, d, a, b;
            logic [6:0] k;
            bit ok;
            note = int'(rom_mem[i]);
            tries = 0;
            ok = 1'b0;
            while (!ok) begin
                wait_ev();
                act = pick(mode, i, tries);
                if (mode == 1) d = 0;
                else if (mode == 4 && i == 0) d = TO_T - 2;
                else d = int'($urandom_range(0, TO_T - 2));
                case (act)
                    0: begin
                        h = sat(h + 1);
                        push(K_WAIT, note, d + 2);
                        push(K_PLAY, note, NOTE_T);
                        if (i == leff - 1) push(K_DONE, note, GAP_T);
                        press_at(d, 7'(1 << note), $urandom_range(0, 3) == 0);
                        ok = 1'b1;
                    end
                    1, 2: begin
                        a = int'($urandom_range(0, 6));
                        b = (a + 1 + int'($urandom_range(0, 5))) % 7;
                        if (act == 1) begin
                            a = (mode == 3) ? 3 : (note + 1 + int'($urandom_range(0, 5))) % 7;
                            k = 7'(1 << a);
                        end else if (mode == 4) begin
                            k = 7'b0010001;
                        end else begin
                            k = 7'((1 << a) | (1 << b));
                        end
                        m = sat(m + 1);
                        push(K_WAIT, note, d + 2);
                        push(K_ERR, note, ERR_T);
                        press_at(d, k, 1'b0);
                    end
                    default: begin
                        m = sat(m + 1);
                        push(K_WAIT, note, TO_T);
                        push(K_ERR, note, ERR_T);
                        wait_fall();
                    end
                endcase
                tries++;
            end
        end
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by 90000 cycles, want completion");
        $fatal(1);
    end

    initial begin
        rom_mem[0] = 4'd0; rom_mem[1] = 4'd0; rom_mem[2] = 4'd4; rom_mem[3] = 4'd5;
        for (int i = 4; i < 32; i++) rom_mem[i] = 4'($urandom_range(0, 6));
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.song_len = '0;
        bus.user_keys = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({bus.rom_addr, bus.key_on, bus.key, bus.expected_key,
              bus.expected_valid, bus.err_flash, bus.busy, bus.done}), 0);
        check("reset_scores", int'({bus.hits, bus.misses}), 0);
        rst = 1'b0;
        @(negedge clk);

        bus.user_keys = 7'b0000100;
        @(negedge clk);
        check("freeplay_key_on", int'(bus.key_on), 1);
        check("freeplay_key", int'(bus.key), 2);
        bus.user_keys = 7'b0000110;
        @(negedge clk);
        check("freeplay_chord_key_on", int'(bus.key_on), 0);
        check("freeplay_chord_key_hold", int'(bus.key), 2);
        bus.user_keys = '0;
        @(negedge clk);

        run_lesson(4, 2);
        run_lesson(4, 3);
        run_lesson(4, 4);

        // Abort two cycles into the first note's PLAY.
        bus.song_len = 5'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        h = 1;
        m = 0;
        wait_ev();
        push(K_WAIT, 0, 3);
        push(K_PLAY, 0, 2);
        press_at(1, 7'b0000001, 1'b0);
        for (int n = 0; n < 20 && !bus.key_on; n++) @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_key_on", int'(bus.key_on), 0);
        check("abort_hits_kept", int'(bus.hits), 1);
        check("abort_misses_kept", int'(bus.misses), 0);

        run_lesson(1, 0);
        run_lesson(0, 0);
        run_lesson(31, 0);
        run_lesson(3, 1);
        for (int r = 0; r < 3; r++) run_lesson(int'($urandom_range(1, 31)), 0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/learn_mode_sequencer.md
Name: learn_mode_sequencer

Overview:
- Sequences learning mode: fetches each note of the selected song from the song ROM and shows it as the expected key.
- Waits for the player's key press, checks it, then plays the note or flags an error.
- Owns the buzzer note interface (key_on/key). While idle, the keyboard passes straight through (free play), so it also arbitrates the buzzer between free play and learning mode.
- Sits between the keyboard debouncer, the song ROM, the buzzer driver and the LED/score display.

Parameters:
- NOTE_TICKS, 50_000_000, clk cycles the confirmed note sounds.
- GAP_TICKS, 25_000_000, silent cycles after a note before the next fetch.
- ERR_TICKS, 25_000_000, cycles err_flash stays high after a wrong or late press.
- TIMEOUT_TICKS, 500_000_000, cycles allowed in WAIT_KEY before a miss.
- Internal tick counter: 32 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a lesson. Ignored unless in IDLE or DONE.
- abort  in  1  level; returns to IDLE next cycle from any state.
- song_len  in  5  number of notes (1..31). Sampled on start; 0 is treated as 1.
- user_keys  in  7  debounced keyboard, one-hot; bit n = note n (C..B).
- rom_addr  out  5  song ROM address.
- rom_data  in  4  note code; valid one cycle after rom_addr changes.
- key_on  out  1  buzzer enable.
- key  out  4  buzzer note code.
- expected_key  out  4  note the player must press.
- expected_valid  out  1  high in WAIT_KEY only.
- err_flash  out  1  high in ERROR.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- hits  out  8  correct presses, saturating at 255.
- misses  out  8  wrong presses plus timeouts, saturating at 255.

Behaviour:
- Reset values: all outputs 0, state IDLE, note index 0, counter 0.
- Press detection: press = user_keys != 0 this cycle and == 0 the previous cycle (registered). A press with more than one bit set is a wrong press. A key held across states generates no new press.
- IDLE:
  - Free play: key_on = 1 iff exactly one user_keys bit set; key = its index, else key holds its last value.
  - start -> FETCH with index 0, hits/misses cleared.
- FETCH (1 cycle): rom_addr <= index -> LOAD.
- LOAD (1 cycle): expected_key <= rom_data; counter cleared -> WAIT_KEY.
- WAIT_KEY:
  - Counter increments; key_on = 0.
  - Press with the encoded index equal to expected_key: hits+1 -> PLAY.
  - Any other press: misses+1 -> ERROR.
  - Counter reaching TIMEOUT_TICKS-1 with no press: misses+1 -> ERROR.
  - A press and timeout in the same cycle: the press wins.
- PLAY: key = expected_key, key_on = 1 for exactly NOTE_TICKS cycles -> GAP.
- GAP:
  - key_on = 0 for GAP_TICKS cycles.
  - Then, if index == len-1 -> DONE; else index+1 -> FETCH.
- ERROR: err_flash = 1, key_on = 0 for ERR_TICKS cycles -> WAIT_KEY on the same note, counter cleared. Presses during ERROR are ignored.
- DONE:
  - done = 1, key_on = 0; hits/misses held.
  - start -> new lesson, same as from IDLE.
  - Free play is not active in DONE.
- abort or rst mid-lesson: key_on drops the next cycle, state IDLE, hits/misses keep their values (rst clears them).
- start while busy is ignored.
- abort has priority over start in the same cycle.
- Counters never wrap: hits/misses stop at 255.
- Index wrap is not possible; the lesson ends at len-1.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2, ERR_TICKS=3, TIMEOUT_TICKS=10; ROM = 0,0,4,5):
- rst, then idle user_keys=7'b0000100 -> key_on=1, key=2 the next cycle. user_keys=7'b0000110 -> key_on=0.
- start, song_len=4, correct presses 0,0,4,5 -> each PLAY has key_on high for exactly 4 cycles, followed by 2 low. Ends with done=1, hits=4, misses=0.
- start, first press is key 3 (expected 0) -> err_flash high for 3 cycles, misses=1, back in WAIT_KEY with expected_key=0. A correct press then gives hits=1.
- Lesson with no press for 10 cycles -> misses=1, ERROR entered, same note retried.
- abort asserted during PLAY -> key_on=0, busy=0 the next cycle, hits retained. Key held from before a new start produces no press.
- Two-key press user_keys=7'b0010001 in WAIT_KEY -> miss. A press and timeout in the same cycle -> counted as the press.
